// File: rtl/cskipa_seq_ctrl.sv
// Sequential WIDTH-bit adder: arbitrates two requesters and walks an external 4-bit carry-skip slice one nibble per cycle.
// Latency: o_valid rises NIB+1 cycles after the accept edge (NIB RUN cycles, then DONE); o_ack pulses the cycle after accept.
// Backpressure: the result is held in DONE until i_ready; requests are only sampled in IDLE, never queued.
// Optional macro CSKIPA_SEQ_CARRY_IN_EN adds per-requester carry-in ports i_cin0/i_cin1.
module cskipa_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req0,
  input  logic [WIDTH-1:0] i_add_term1_0,
  input  logic [WIDTH-1:0] i_add_term2_0,
  output logic             o_ack0,
  input  logic             i_req1,
  input  logic [WIDTH-1:0] i_add_term1_1,
  input  logic [WIDTH-1:0] i_add_term2_1,
  output logic             o_ack1,
`ifdef CSKIPA_SEQ_CARRY_IN_EN
  input  logic             i_cin0,
  input  logic             i_cin1,
`endif
  output logic [3:0]       o_slice_a,
  output logic [3:0]       o_slice_b,
  output logic             o_slice_cin,
  input  logic [3:0]       i_slice_sum,
  input  logic             i_slice_cout,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_id,
  output logic             o_busy
);

  localparam int NIB = WIDTH / 4;
  localparam int SW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(NIB - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [SW-1:0]    step_q;
  logic             id_q;
  logic             last_q;   // last served requester; 1 after reset so requester 0 is favoured
  logic             ack0_q;
  logic             ack1_q;

  logic             any_req;
  logic             grant_id;
  logic [WIDTH-1:0] grant_a;
  logic [WIDTH-1:0] grant_b;
  logic             grant_cin;
  logic             run;
  logic [SW+1:0]    bit_idx;

  // Round-robin grant: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    any_req  = i_req0 | i_req1;
    grant_id = (i_req0 & i_req1) ? ~last_q : i_req1;
    grant_a  = grant_id ? i_add_term1_1 : i_add_term1_0;
    grant_b  = grant_id ? i_add_term2_1 : i_add_term2_0;
`ifdef CSKIPA_SEQ_CARRY_IN_EN
    grant_cin = grant_id ? i_cin1 : i_cin0;
`else
    grant_cin = 1'b0;
`endif
  end

  // Slice drive: current nibble of A/B plus running carry, forced to zero outside RUN.
  always_comb begin
    run         = (state_q == ST_RUN);
    bit_idx     = {step_q, 2'b00};
    o_slice_a   = run ? a_q[bit_idx +: 4] : 4'h0;
    o_slice_b   = run ? b_q[bit_idx +: 4] : 4'h0;
    o_slice_cin = run ? carry_q : 1'b0;
  end

  // Control FSM plus operand, result and carry datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      step_q  <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            a_q     <= grant_a;
            b_q     <= grant_b;
            carry_q <= grant_cin;
            step_q  <= '0;
            id_q    <= grant_id;
            last_q  <= grant_id;
            ack0_q  <= ~grant_id;
            ack1_q  <= grant_id;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q[bit_idx +: 4] <= i_slice_sum;
          carry_q             <= i_slice_cout;
          if (step_q == STEP_LAST) begin
            state_q <= ST_DONE;
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Result and status outputs come straight from registers, so they stay stable under backpressure.
  always_comb begin
    o_ack0  = ack0_q;
    o_ack1  = ack1_q;
    o_valid = (state_q == ST_DONE);
    o_busy  = (state_q != ST_IDLE);
    o_sum   = res_q;
    o_cout  = carry_q;
    o_id    = id_q;
  end

endmodule

// File: tb/tb_cskipa_seq_ctrl.sv
// Directed bench for cskipa_seq_ctrl at WIDTH=16 with a behavioural 4-bit slice.
// Covers reset state, single add, round-robin, backpressure hold, mid-RUN reset, carry-in build option, random ops.
// Inputs are driven and outputs sampled on the falling edge.
module tb_cskipa_seq_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_req0, i_req1;
  logic [WIDTH-1:0] i_add_term1_0, i_add_term2_0, i_add_term1_1, i_add_term2_1;
  logic             o_ack0, o_ack1;
`ifdef CSKIPA_SEQ_CARRY_IN_EN
  logic             i_cin0, i_cin1;
`endif
  logic [3:0]       o_slice_a, o_slice_b, i_slice_sum;
  logic             o_slice_cin, i_slice_cout;
  logic             o_valid, i_ready, o_cout, o_id, o_busy;
  logic [WIDTH-1:0] o_sum;
  logic [4:0]       slice_full;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cskipa_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .i_req0(i_req0), .i_add_term1_0(i_add_term1_0), .i_add_term2_0(i_add_term2_0), .o_ack0(o_ack0),
    .i_req1(i_req1), .i_add_term1_1(i_add_term1_1), .i_add_term2_1(i_add_term2_1), .o_ack1(o_ack1),
`ifdef CSKIPA_SEQ_CARRY_IN_EN
    .i_cin0(i_cin0), .i_cin1(i_cin1),
`endif
    .o_slice_a(o_slice_a), .o_slice_b(o_slice_b), .o_slice_cin(o_slice_cin),
    .i_slice_sum(i_slice_sum), .i_slice_cout(i_slice_cout),
    .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_cout(o_cout),
    .o_id(o_id), .o_busy(o_busy)
  );

  // External combinational slice: plain 4-bit add with carry.
  assign slice_full   = {1'b0, o_slice_a} + {1'b0, o_slice_b} + {4'b0, o_slice_cin};
  assign i_slice_sum  = slice_full[3:0];
  assign i_slice_cout = slice_full[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // All externally visible outputs must be zero (reset / idle-after-reset).
  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_ack"},   {o_ack0, o_ack1}, 0);
    check({tag, "_sum"},   o_sum, 0);
    check({tag, "_cout"},  o_cout, 0);
    check({tag, "_id"},    o_id, 0);
    check({tag, "_slice"}, {o_slice_a, o_slice_b, o_slice_cin}, 0);
  endtask

  // Present one request for a single accept edge; returns in the first cycle after accept.
  task automatic issue(input bit who, input logic [15:0] a, input logic [15:0] b, input bit cin);
    if (who) begin
      i_req1 = 1'b1; i_add_term1_1 = a; i_add_term2_1 = b;
    end else begin
      i_req0 = 1'b1; i_add_term1_0 = a; i_add_term2_0 = b;
    end
`ifdef CSKIPA_SEQ_CARRY_IN_EN
    if (who) i_cin1 = cin; else i_cin0 = cin;
`else
    if (cin) i_req0 = i_req0;
`endif
    @(negedge clk);
    i_req0 = 1'b0;
    i_req1 = 1'b0;
  endtask

  // Count cycles (starting at 1 = first cycle after accept) until o_valid.
  task automatic wait_valid(input string tag, output int lat);
    lat = 1;
    while (!o_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!o_valid) check({tag, "_timeout"}, o_valid, 1);
  endtask

  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b, input bit cin);
`ifdef CSKIPA_SEQ_CARRY_IN_EN
    return {1'b0, a} + {1'b0, b} + {16'b0, cin};
`else
    return {1'b0, a} + {1'b0, b} + {16'b0, cin & 1'b0};
`endif
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [16:0] exp;
    logic [15:0] held_sum;

    rst = 1'b1; i_req0 = 0; i_req1 = 0; i_ready = 0;
    i_add_term1_0 = 0; i_add_term2_0 = 0; i_add_term1_1 = 0; i_add_term2_1 = 0;
`ifdef CSKIPA_SEQ_CARRY_IN_EN
    i_cin0 = 0; i_cin1 = 0;
`endif
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Single add from requester 0: 0x1234 + 0x0FCD = 0x2201.
    issue(0, 16'h1234, 16'h0FCD, 0);
    check("t1_ack0", o_ack0, 1);
    check("t1_ack1", o_ack1, 0);
    check("t1_busy", o_busy, 1);
    check("t1_step0_slice", {o_slice_a, o_slice_b, o_slice_cin}, {4'h4, 4'hD, 1'b0});
    @(negedge clk);
    check("t1_ack_pulse", o_ack0, 0);
    check("t1_step1_slice", {o_slice_a, o_slice_b, o_slice_cin}, {4'h3, 4'hC, 1'b1});
    lat = 2;
    while (!o_valid && lat < 30) begin @(negedge clk); lat++; end
    check("t1_latency", lat, 5);
    check("t1_sum", o_sum, 16'h2201);
    check("t1_cout", o_cout, 0);
    check("t1_id", o_id, 0);
    check("t1_done_slice", {o_slice_a, o_slice_b, o_slice_cin}, 0);

    // Backpressure: three cycles with i_ready low hold the result.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", {o_valid, o_sum, o_cout, o_id}, {1'b1, 16'h2201, 1'b0, 1'b0});
    end
    i_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", o_valid, 0);
    check("bp_release_busy", o_busy, 0);
    i_ready = 1'b0;

    // Reset during RUN step 2 of a requester-0 add; pointer must return to favour requester 0.
    issue(0, 16'h1111, 16'h2222, 0);
    repeat (2) @(negedge clk);
    check("mid_step2_slice", {o_slice_a, o_slice_b}, {4'h1, 4'h2});
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_rst");
    rst = 1'b0;

    // Both requests held from reset with i_ready high: grants alternate 0,1,0.
    i_ready = 1'b1;
    i_req0 = 1'b1; i_add_term1_0 = 16'hFFFF; i_add_term2_0 = 16'h0001;
    i_req1 = 1'b1; i_add_term1_1 = 16'h8000; i_add_term2_1 = 16'h8000;
    @(negedge clk);
    check("rr_first_ack", {o_ack0, o_ack1}, 2'b10);
    for (int r = 0; r < 3; r++) begin
      wait_valid("rr", lat);
      check("rr_id", o_id, (r == 1) ? 1 : 0);
      check("rr_sum", o_sum, 16'h0000);
      check("rr_cout", o_cout, 1);
      if (r == 2) begin i_req0 = 1'b0; i_req1 = 1'b0; end
      @(negedge clk);
    end
    i_ready = 1'b0;
    @(negedge clk);
    check("rr_idle", o_busy, 0);

    // Carry-in option: 0x00FF + 0x0000 with cin0 = 1.
    issue(0, 16'h00FF, 16'h0000, 1);
`ifdef CSKIPA_SEQ_CARRY_IN_EN
    check("cin_step0", o_slice_cin, 1);
`else
    check("cin_step0", o_slice_cin, 0);
`endif
    exp = ref_add(16'h00FF, 16'h0000, 1);
    wait_valid("cin", lat);
    check("cin_sum", o_sum, exp[15:0]);
    check("cin_cout", o_cout, exp[16]);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;

    // Random operations with random consumer stalls.
    for (int n = 0; n < 200; n++) begin
      bit who, cin, rdy, done;
      logic [15:0] a, b;
      int h;
      who = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      exp = ref_add(a, b, cin);
      issue(who, a, b, cin);
      check("rnd_ack", {o_ack1, o_ack0}, who ? 2'b10 : 2'b01);
      wait_valid("rnd", lat);
      check("rnd_latency", lat, 5);
      check("rnd_result", {o_id, o_cout, o_sum}, {who, exp});
      held_sum = o_sum;
      done = 0;
      h = 0;
      while (!done) begin
        rdy = (h >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        i_ready = rdy;
        @(negedge clk);
        h++;
        if (rdy) begin
          check("rnd_release", o_valid, 0);
          done = 1;
        end else begin
          check("rnd_hold", {o_valid, o_sum}, {1'b1, held_sum});
        end
      end
      i_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cskipa_seq_ctrl.md
CSKIPA_SEQ_CTRL -- requirements
Module: cskipa_seq_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 SHALL have derived constant NIB = WIDTH/4, the number of nibble steps per addition.
REQ-003 SHALL have ports:
- clk  input  1  clock; one clock.
- rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have requester 0 ports:
- i_req0  input  1  request from requester 0.
- i_add_term1_0  input  WIDTH  operand A, requester 0.
- i_add_term2_0  input  WIDTH  operand B, requester 0.
- o_ack0  output  1  one-cycle accept pulse.
REQ-005 SHALL have requester 1 ports i_req1, i_add_term1_1, i_add_term2_1 and o_ack1, mirroring REQ-004.
REQ-006 SHALL have slice ports, connecting to an external combinational 4-bit carry-skip slice:
- o_slice_a  output  4  slice operand A.
- o_slice_b  output  4  slice operand B.
- o_slice_cin  output  1  slice carry-in.
- i_slice_sum  input  4  slice sum.
- i_slice_cout  input  1  slice carry-out.
REQ-007 SHALL have result ports:
- o_valid  output  1  result valid.
- i_ready  input  1  result consumer ready.
- o_sum  output  WIDTH  sum.
- o_cout  output  1  final carry-out.
- o_id  output  1  requester tag for the result.
- o_busy  output  1  high in every state except IDLE.

Function
REQ-008 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-009 In IDLE, on a clock edge with any request asserted, SHALL:
- grant one requester;
- latch its operands into internal A/B registers;
- clear the carry register (or load carry-in, see REQ-020);
- clear the step counter and move to RUN;
- pulse the matching o_ack for exactly the cycle following that edge.
REQ-010 Arbitration SHALL be round-robin with a last-served pointer:
- single request: that requester wins;
- both requesting: the requester not last served wins;
- after reset the pointer SHALL favour requester 0.
REQ-011 In RUN, step k (0..NIB-1), SHALL drive:
- o_slice_a = A[4k+3:4k] and o_slice_b = B[4k+3:4k];
- o_slice_cin = the carry register.
At each RUN edge it SHALL store i_slice_sum into result bits [4k+3:4k] and i_slice_cout into the carry register.
REQ-012 After step NIB-1 the FSM SHALL enter DONE; the total is exactly NIB RUN cycles.
REQ-013 In DONE, o_valid SHALL be 1, with o_sum = the assembled result, o_cout = the carry register and o_id = the granted requester.
REQ-014 Outputs SHALL hold stable while o_valid=1 and i_ready=0; a DONE edge with i_ready=1 SHALL return the FSM to IDLE.
REQ-015 Requests arriving in RUN or DONE SHALL be ignored, not queued; a requester holds i_req until its o_ack.
REQ-016 Outside RUN, o_slice_a, o_slice_b and o_slice_cin SHALL be 0.
REQ-017 Latency from the accept edge to o_valid=1 SHALL be NIB+1 cycles; the earliest next accept is on the cycle after the handshake edge.
REQ-018 Arithmetic SHALL be modulo 2^WIDTH on o_sum, with the carry out of bit WIDTH-1 on o_cout; o_sum SHALL equal A+B+cin exactly.

Reset
REQ-019 When rst is high at a clock edge, the block SHALL enter IDLE regardless of state, including mid-RUN or in DONE with o_valid pending. It SHALL:
- drive o_valid, o_ack0, o_ack1, o_busy, o_cout, o_id and all slice outputs to 0;
- clear o_sum, the A/B registers and the carry register to 0;
- set the round-robin pointer to favour requester 0.
Any in-flight result SHALL be discarded.

Configuration
REQ-020 Macro CSKIPA_SEQ_CARRY_IN_EN, when defined:
- SHALL add ports i_cin0 and i_cin1 (input, 1 bit each);
- the granted requester's cin SHALL be loaded into the carry register at accept and used as o_slice_cin in step 0.
When undefined, these ports SHALL be absent and the initial carry SHALL be 0.

Verification
REQ-021 WIDTH=16, req0 only, A=0x1234, B=0x0FCD -> o_ack0 pulse; o_valid 5 cycles after accept; o_sum=0x2201, o_cout=0, o_id=0.
REQ-022 WIDTH=16, both requests held every cycle from reset, operands 0xFFFF+0x0001 (req0) and 0x8000+0x8000 (req1), i_ready=1 -> results:
- first: o_id=0, o_sum=0x0000, o_cout=1;
- then: o_id=1, o_sum=0x0000, o_cout=1;
- then: o_id=0 again.
REQ-023 Backpressure: i_ready=0 for 3 cycles in DONE -> o_valid, o_sum, o_cout and o_id unchanged; IDLE entered on the first edge with i_ready=1.
REQ-024 rst asserted during RUN step 2 -> next cycle: IDLE, all outputs 0, no o_valid; a subsequent req1 is granted when req0 is also asserted only if the pointer rule allows, i.e. req0 wins.
REQ-025 CSKIPA_SEQ_CARRY_IN_EN defined, A=0x00FF, B=0x0000, i_cin0=1 -> o_sum=0x0100, o_cout=0; undefined build, same operands -> o_sum=0x00FF.
REQ-026 Random regression, 10^4 operations on both requesters with random i_ready, against a reference model: o_sum/o_cout always equal A+B(+cin); acks and results never lost or duplicated.
